// File: rtl/dmem_pkg.sv
// Shared types and defaults for the parametrised data memory controller.
// The byte-lane count helper is used by both the controller and the array.
package dmem_pkg;

   typedef enum logic [0:0] {
      DM_CLEAR = 1'b0,
      DM_IDLE  = 1'b1
   } dm_state_e;

   localparam int DM_DATA_W_DEF = 8;
   localparam int DM_ADDR_W_DEF = 8;
   localparam int DM_DEPTH_DEF  = 256;

   // Number of byte lanes in a word; returns 0 for widths that are not whole bytes
   // so the enclosing module's elaboration check can reject them.
   function automatic int dm_nb(input int data_w);
      if ((data_w % 8) != 0) begin
         return 0;
      end else begin
         return data_w / 8;
      end
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Parametrised single-port RAM with per-byte write strobes and a registered read port.
// Kept reset-free so it maps onto block RAM.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int  DATA_W = DM_DATA_W_DEF,
   parameter int  AW     = DM_ADDR_W_DEF,
   parameter int  DEPTH  = DM_DEPTH_DEF,
   localparam int NB     = dm_nb(DATA_W)
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [AW-1:0]     adr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [NB-1:0]     wstrb,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [DATA_W-1:0] rdata_r;

   // Lane-masked synchronous write
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < NB; i++) begin
            if (wstrb[i]) begin
               mem_r[adr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   // Registered read; holds the last word read while re is low
   always_ff @(posedge clk) begin
      if (re) begin
         rdata_r <= mem_r[adr];
      end
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/data_memory_ctrl.sv
// Load/store data memory controller: clear sequencer, range check, request/ready
// handshake and valid-qualified registered read in front of a byte-strobed RAM.
module data_memory_ctrl
   import dmem_pkg::*;
#(
   parameter int  DATA_W = DM_DATA_W_DEF,
   parameter int  ADDR_W = DM_ADDR_W_DEF,
   parameter int  DEPTH  = DM_DEPTH_DEF,
   localparam int NB     = dm_nb(DATA_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_req,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] adr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [NB-1:0]     wstrb,
   output logic              ready,
   output logic              rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   output logic              busy
);

   localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);

   if ((DATA_W < 8) || ((DATA_W % 8) != 0)) begin : g_bad_data_w
      $error("data_memory_ctrl: DATA_W must be a positive multiple of 8");
   end
   if ((DEPTH < 1) || (DEPTH > (2 ** ADDR_W))) begin : g_bad_depth
      $error("data_memory_ctrl: DEPTH must lie in 1 .. 2**ADDR_W");
   end

   dm_state_e         state_r;
   dm_state_e         state_nxt_s;
   logic [ADDR_W:0]   cnt_r;
   logic [ADDR_W:0]   cnt_nxt_s;
   logic              ready_r;
   logic              busy_r;
   logic              rvalid_r;
   logic              err_r;
   logic              rd_ok_r;
   logic              acc_s;
   logic              in_range_s;
   logic              mem_we_s;
   logic              mem_re_s;
   logic [AW-1:0]     mem_adr_s;
   logic [DATA_W-1:0] mem_wdata_s;
   logic [NB-1:0]     mem_wstrb_s;
   logic [DATA_W-1:0] mem_rdata_s;

   assign acc_s      = req & ready_r;
   assign in_range_s = ({1'b0, adr} < DEPTH_C);

   // Next-state and clear-counter logic
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         DM_CLEAR: begin
            if (clr_req) begin
               cnt_nxt_s = '0;
            end else if (cnt_r == LAST_C) begin
               state_nxt_s = DM_IDLE;
               cnt_nxt_s   = '0;
            end else begin
               cnt_nxt_s = cnt_r + {{ADDR_W{1'b0}}, 1'b1};
            end
         end
         DM_IDLE: begin
            if (clr_req) begin
               state_nxt_s = DM_CLEAR;
               cnt_nxt_s   = '0;
            end else begin
               state_nxt_s = DM_IDLE;
               cnt_nxt_s   = '0;
            end
         end
         default: begin
            state_nxt_s = DM_CLEAR;
            cnt_nxt_s   = '0;
         end
      endcase
   end

   // Array port steering: the sweep owns the port while clearing
   always_comb begin
      mem_we_s    = 1'b0;
      mem_re_s    = 1'b0;
      mem_adr_s   = adr[AW-1:0];
      mem_wdata_s = wdata;
      mem_wstrb_s = wstrb;
      if (state_r == DM_CLEAR) begin
         mem_we_s    = 1'b1;
         mem_adr_s   = cnt_r[AW-1:0];
         mem_wdata_s = '0;
         mem_wstrb_s = '1;
      end else begin
         mem_we_s = acc_s & we & in_range_s;
         mem_re_s = acc_s & ~we & in_range_s;
      end
   end

   // State, counter and handshake flags; ready/busy follow the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= DM_CLEAR;
         cnt_r   <= '0;
         ready_r <= 1'b0;
         busy_r  <= 1'b1;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         ready_r <= (state_nxt_s == DM_IDLE);
         busy_r  <= (state_nxt_s == DM_CLEAR);
      end
   end

   // Response pulses; rd_ok_r masks rdata to zero after reset or an out-of-range read
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid_r <= 1'b0;
         err_r    <= 1'b0;
         rd_ok_r  <= 1'b0;
      end else begin
         rvalid_r <= acc_s & ~we;
         err_r    <= acc_s & ~in_range_s;
         if (acc_s & ~we) begin
            rd_ok_r <= in_range_s;
         end
      end
   end

   dmem_array #(
      .DATA_W (DATA_W),
      .AW     (AW),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk   (clk),
      .we    (mem_we_s),
      .re    (mem_re_s),
      .adr   (mem_adr_s),
      .wdata (mem_wdata_s),
      .wstrb (mem_wstrb_s),
      .rdata (mem_rdata_s)
   );

   assign ready  = ready_r;
   assign busy   = busy_r;
   assign rvalid = rvalid_r;
   assign err    = err_r;
   assign rdata  = mem_rdata_s & {DATA_W{rd_ok_r}};

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed self-checking bench for data_memory_ctrl (32-bit words, 12-word array).
module tb_data_memory_ctrl;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 12;
   localparam int NB     = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              clr_req;
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] adr;
   logic [DATA_W-1:0] wdata;
   logic [NB-1:0]     wstrb;
   logic              ready;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;
   logic              err;
   logic              busy;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   data_memory_ctrl #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_req (clr_req),
      .req     (req),
      .we      (we),
      .adr     (adr),
      .wdata   (wdata),
      .wstrb   (wstrb),
      .ready   (ready),
      .rvalid  (rvalid),
      .rdata   (rdata),
      .err     (err),
      .busy    (busy)
   );

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One accepted access; on return the outputs reflect its completion
   task automatic acc(input logic w, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      req   = 1'b1;
      we    = w;
      adr   = a;
      wdata = d;
      wstrb = s;
      tick();
      req   = 1'b0;
      we    = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
      acc(1'b0, a, 32'h0, 4'h0);
      chk_eq({tag, "_rvalid"}, {31'h0, rvalid}, 32'h1);
      chk_eq({tag, "_rdata"}, rdata, exp);
      chk_eq({tag, "_err"}, {31'h0, err}, 32'h0);
   endtask

   // Counts edges until busy drops; bounded so a stuck sweep still finishes
   task automatic sweep_len(input string tag, input int exp);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (busy && (n < 40));
      chk_eq({tag, "_len"}, n, exp);
      chk_eq({tag, "_ready"}, {31'h0, ready}, 32'h1);
   endtask

   initial begin
      rst_n   = 1'b0;
      clr_req = 1'b0;
      req     = 1'b0;
      we      = 1'b0;
      adr     = 4'h0;
      wdata   = 32'h0;
      wstrb   = 4'h0;

      // Reset state
      tick();
      tick();
      chk_eq("rst_ready", {31'h0, ready}, 32'h0);
      chk_eq("rst_busy", {31'h0, busy}, 32'h1);
      chk_eq("rst_rvalid", {31'h0, rvalid}, 32'h0);
      chk_eq("rst_err", {31'h0, err}, 32'h0);
      chk_eq("rst_rdata", rdata, 32'h0);

      // Power-up sweep, then every word reads zero
      rst_n = 1'b1;
      sweep_len("sweep0", 12);
      for (int i = 0; i < DEPTH; i++) begin
         rd_chk($sformatf("clr0_a%0d", i), 4'(i), 32'h0);
      end

      // Byte strobes
      acc(1'b1, 4'd3, 32'hAABBCCDD, 4'b1111);
      chk_eq("wr_no_rvalid", {31'h0, rvalid}, 32'h0);
      chk_eq("wr_no_err", {31'h0, err}, 32'h0);
      acc(1'b1, 4'd3, 32'h11223344, 4'b0101);
      rd_chk("strb", 4'd3, 32'hAA22CC44);
      acc(1'b1, 4'd3, 32'hFFFFFFFF, 4'b0000);
      rd_chk("strb_none", 4'd3, 32'hAA22CC44);
      tick();
      chk_eq("rvalid_pulse", {31'h0, rvalid}, 32'h0);

      // Out of range and the last valid word
      acc(1'b1, 4'd13, 32'hDEADBEEF, 4'b1111);
      chk_eq("oor_wr_err", {31'h0, err}, 32'h1);
      chk_eq("oor_wr_rvalid", {31'h0, rvalid}, 32'h0);
      tick();
      chk_eq("err_pulse", {31'h0, err}, 32'h0);
      acc(1'b0, 4'd13, 32'h0, 4'h0);
      chk_eq("oor_rd_rvalid", {31'h0, rvalid}, 32'h1);
      chk_eq("oor_rd_err", {31'h0, err}, 32'h1);
      chk_eq("oor_rd_rdata", rdata, 32'h0);
      acc(1'b0, 4'd12, 32'h0, 4'h0);
      chk_eq("oor12_err", {31'h0, err}, 32'h1);
      rd_chk("last_word", 4'd11, 32'h0);
      rd_chk("alias1", 4'd1, 32'h0);

      // Read-after-write and streaming reads
      req = 1'b1; we = 1'b1; adr = 4'd2; wdata = 32'h0000005A; wstrb = 4'b1111;
      tick();
      we = 1'b0; adr = 4'd2;
      tick();
      chk_eq("raw_v0", {31'h0, rvalid}, 32'h1);
      chk_eq("raw_d0", rdata, 32'h0000005A);
      adr = 4'd2;
      tick();
      chk_eq("raw_v1", {31'h0, rvalid}, 32'h1);
      chk_eq("raw_d1", rdata, 32'h0000005A);
      adr = 4'd0;
      tick();
      chk_eq("raw_v2", {31'h0, rvalid}, 32'h1);
      chk_eq("raw_d2", rdata, 32'h0);
      req = 1'b0;
      tick();
      chk_eq("raw_end", {31'h0, rvalid}, 32'h0);
      chk_eq("raw_hold", rdata, 32'h0);

      // On-demand clear with a simultaneous write
      for (int i = 0; i < DEPTH; i++) begin
         acc(1'b1, 4'(i), 32'hFFFFFFFF, 4'b1111);
      end
      rd_chk("fill", 4'd7, 32'hFFFFFFFF);
      clr_req = 1'b1;
      req = 1'b1; we = 1'b1; adr = 4'd5; wdata = 32'h12345678; wstrb = 4'b1111;
      tick();
      clr_req = 1'b0;
      req = 1'b0; we = 1'b0;
      chk_eq("clr_ready_drop", {31'h0, ready}, 32'h0);
      chk_eq("clr_busy", {31'h0, busy}, 32'h1);
      chk_eq("clr_wr_err", {31'h0, err}, 32'h0);
      sweep_len("sweep1", 12);
      for (int i = 0; i < DEPTH; i++) begin
         rd_chk($sformatf("clr1_a%0d", i), 4'(i), 32'h0);
      end

      // Async reset in the middle of a sweep
      acc(1'b1, 4'd4, 32'hCAFEF00D, 4'b1111);
      rd_chk("pre_rst", 4'd4, 32'hCAFEF00D);
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk_eq("mid_rst_rdata", rdata, 32'h0);
      chk_eq("mid_rst_busy", {31'h0, busy}, 32'h1);
      chk_eq("mid_rst_ready", {31'h0, ready}, 32'h0);
      chk_eq("mid_rst_rvalid", {31'h0, rvalid}, 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      sweep_len("sweep2", 12);
      rd_chk("post_rst", 4'd4, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
